// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared branch-predictor definitions used by the direction predictor and
// its saturating-counter helper.
//   IDX_W_DEFAULT : log2 of the pattern-table depth (64 entries)
//   PC_W_DEFAULT  : instruction address width
//   ctr_state_e   : two-bit counter encodings (strong/weak not-taken/taken)
//   CTR_MAX/MIN   : saturation limits of the counters
//   CTR_RESET     : value every counter takes while reset is held
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam int IDX_W_DEFAULT = 6;
   localparam int PC_W_DEFAULT  = 16;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_state_e;

   localparam logic [1:0] CTR_MAX   = ST;
   localparam logic [1:0] CTR_MIN   = SNT;
   localparam logic [1:0] CTR_RESET = WNT;

endpackage

// File: rtl/bht_sat_ctr.sv
// ---------------------------------------------------------------------------
// bht_sat_ctr
// Next-state logic for one two-bit saturating direction counter.
// Ports:
//   cur   : current counter value
//   taken : resolved branch outcome (1 = taken)
//   next  : updated counter value, clamped to CTR_MIN..CTR_MAX
// ---------------------------------------------------------------------------
module bht_sat_ctr
   import bp_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] next
);

   // A taken branch moves the counter toward strong-taken and a not-taken
   // branch toward strong-not-taken; at either end the value is held so the
   // counter never wraps around.
   always_comb begin
      next = cur;
      if (taken) begin
         if (cur != CTR_MAX) begin
            next = cur + 2'd1;
         end
      end else begin
         if (cur != CTR_MIN) begin
            next = cur - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
// gshare direction predictor: a flop-based table of 2**IDX_W two-bit
// saturating counters indexed by (word-aligned PC bits XOR speculative
// global history).
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   en            : predictor enable; when low predictions are forced to
//                   not-taken and history/table are frozen
//   if_valid      : fetch lookup presented this cycle
//   if_pc         : fetch PC
//   pred_taken    : combinational direction prediction for if_pc
//   pred_ghr      : history used for this lookup, carried down the pipe
//   ex_valid      : conditional branch resolved in EX this cycle
//   ex_pc         : resolved branch PC
//   ex_ghr        : pred_ghr captured at that branch's lookup
//   ex_taken      : actual outcome
//   ex_mispredict : predicted direction was wrong
//   mispred_cnt   : saturating count of mispredictions since reset
// ---------------------------------------------------------------------------
module branch_history_table
   import bp_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEFAULT,
   parameter int PC_W  = PC_W_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              if_valid,
   input  logic [PC_W-1:0]   if_pc,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_ghr,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [IDX_W-1:0]  ex_ghr,
   input  logic              ex_taken,
   input  logic              ex_mispredict,
   output logic [15:0]       mispred_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]       ctr_tbl [ENTRIES];
   logic [IDX_W-1:0] ghr_spec;
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_cur;
   logic [1:0]       upd_next;
   logic             lk_fire;
   logic             upd_fire;
   logic             recover;
   logic             unused_pc_bits;

   // Instruction words are 2-byte aligned, so bit 0 of the PC carries no
   // information and the index starts at bit 1. Lookup and update hash the
   // same way so a resolved branch trains the entry that predicted it.
   assign lk_idx   = if_pc[IDX_W:1] ^ ghr_spec;
   assign upd_idx  = ex_pc[IDX_W:1] ^ ex_ghr;

   assign lk_fire  = en & if_valid;
   assign upd_fire = en & ex_valid;
   assign recover  = ex_valid & ex_mispredict;

   // The prediction reads the table directly, so a same-cycle update to the
   // same entry is not visible until the following cycle.
   assign pred_taken = lk_fire & ctr_tbl[lk_idx][1];
   assign pred_ghr   = ghr_spec;

   assign upd_cur = ctr_tbl[upd_idx];

   bht_sat_ctr u_sat_ctr (
      .cur   (upd_cur),
      .taken (ex_taken),
      .next  (upd_next)
   );

   assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+1], if_pc[0],
                             ex_pc[PC_W-1:IDX_W+1], ex_pc[0]};

   // Speculative global history. A mispredict rebuilds the history from the
   // branch's own snapshot plus its real outcome, which discards whatever
   // younger lookups shifted in, so it wins over a same-cycle lookup shift.
   // With the predictor disabled the history is frozen entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_spec <= '0;
      end else if (en) begin
         if (recover) begin
            ghr_spec <= {ex_ghr[IDX_W-2:0], ex_taken};
         end else if (if_valid) begin
            ghr_spec <= {ghr_spec[IDX_W-2:0], pred_taken};
         end
      end
   end

   // Pattern table held in flops so that reset reaches every entry; all
   // counters start weakly not-taken. Only the resolved entry is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_tbl[i] <= CTR_RESET;
         end
      end else if (upd_fire) begin
         ctr_tbl[upd_idx] <= upd_next;
      end
   end

   // Misprediction counter keeps counting even with the predictor disabled,
   // and sticks at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispred_cnt <= 16'd0;
      end else if (recover && (mispred_cnt != 16'hFFFF)) begin
         mispred_cnt <= mispred_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_history_table.sv
// ---------------------------------------------------------------------------
// tb_branch_history_table
// Directed testbench for branch_history_table with hand-computed expected
// values. Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_branch_history_table;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        if_valid;
   logic [15:0] if_pc;
   logic        pred_taken;
   logic [5:0]  pred_ghr;
   logic        ex_valid;
   logic [15:0] ex_pc;
   logic [5:0]  ex_ghr;
   logic        ex_taken;
   logic        ex_mispredict;
   logic [15:0] mispred_cnt;

   int   checks;
   int   errors;
   logic exv;

   branch_history_table #(
      .IDX_W (6),
      .PC_W  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_ghr      (pred_ghr),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_ghr        (ex_ghr),
      .ex_taken      (ex_taken),
      .ex_mispredict (ex_mispredict),
      .mispred_cnt   (mispred_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then settle.
   task automatic applyStimulus(input logic e, input logic ifv, input logic [15:0] ipc,
                                input logic exval, input logic [15:0] epc,
                                input logic [5:0] eghr, input logic et, input logic em);
      @(negedge clk);
      en            = e;
      if_valid      = ifv;
      if_pc         = ipc;
      ex_valid      = exval;
      ex_pc         = epc;
      ex_ghr        = eghr;
      ex_taken      = et;
      ex_mispredict = em;
      #1;
   endtask

   task automatic setIdle();
      en            = 1'b1;
      if_valid      = 1'b0;
      if_pc         = 16'h0000;
      ex_valid      = 1'b0;
      ex_pc         = 16'h0000;
      ex_ghr        = 6'd0;
      ex_taken      = 1'b0;
      ex_mispredict = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      setIdle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exv    = 1'b0;
      rst_n  = 1'b0;
      setIdle();
      doReset();

      // Reset state and first lookup at 0x0010 (index 8, weak-NT).
      applyStimulus(1, 1, 16'h0010, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("rst_ghr",  {10'd0, pred_ghr}, 16'd0);
      checkOutput("rst_cnt",  mispred_cnt,       16'd0);
      checkOutput("rst_pred", {15'd0, pred_taken}, 16'd0);

      // Saturate upward: index 8 goes 1->2->3->3.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 16'h0000, 1, 16'h0010, 6'd0, 1, 0);
      end
      applyStimulus(1, 1, 16'h0010, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("sat_up_ghr",  {10'd0, pred_ghr},   16'd0);
      checkOutput("sat_up_pred", {15'd0, pred_taken}, 16'd1);

      // Saturate downward: 3->2->1->0->0->0; lookup then uses ghr=1, pc 0x12.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 16'h0000, 1, 16'h0010, 6'd0, 0, 0);
      end
      applyStimulus(1, 1, 16'h0012, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("sat_dn_ghr",  {10'd0, pred_ghr},   16'd1);
      checkOutput("sat_dn_pred", {15'd0, pred_taken}, 16'd0);

      // History shift: train index 8 and index 5 to strong-T, then look up
      // so predictions come out 1,0,1.
      doReset();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 16'h0000, 1, 16'h0010, 6'd0, 1, 0);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 16'h0000, 1, 16'h000A, 6'd0, 1, 0);
      end
      applyStimulus(1, 1, 16'h0010, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("shift0_ghr",  {10'd0, pred_ghr},   16'd0);
      checkOutput("shift0_pred", {15'd0, pred_taken}, 16'd1);
      applyStimulus(1, 1, 16'h0000, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("shift1_ghr",  {10'd0, pred_ghr},   16'd1);
      checkOutput("shift1_pred", {15'd0, pred_taken}, 16'd0);
      applyStimulus(1, 1, 16'h000E, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("shift2_ghr",  {10'd0, pred_ghr},   16'd2);
      checkOutput("shift2_pred", {15'd0, pred_taken}, 16'd1);

      // A mispredict flag without ex_valid must do nothing.
      applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 6'b101010, 1, 1);
      checkOutput("shift3_ghr", {10'd0, pred_ghr}, 16'd5);

      // Mispredict recovery in the same cycle as a lookup (index 5, taken).
      applyStimulus(1, 1, 16'h0000, 1, 16'h0000, 6'b101010, 1, 1);
      checkOutput("novalid_ghr", {10'd0, pred_ghr},   16'd5);
      checkOutput("novalid_cnt", mispred_cnt,         16'd0);
      checkOutput("recov_pred",  {15'd0, pred_taken}, 16'd1);

      // Collision on index 42 (weak-T): old value predicts taken.
      applyStimulus(1, 1, 16'h007E, 1, 16'h0000, 6'd42, 0, 0);
      checkOutput("recov_ghr", {10'd0, pred_ghr},   16'd21);
      checkOutput("recov_cnt", mispred_cnt,         16'd1);
      checkOutput("coll_old",  {15'd0, pred_taken}, 16'd1);
      applyStimulus(1, 1, 16'h0002, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("coll_ghr", {10'd0, pred_ghr},   16'd43);
      checkOutput("coll_new", {15'd0, pred_taken}, 16'd0);

      // Disabled predictor: ten lookups (first one hits strong-T index 5)
      // and three mispredicting updates that would drain index 5.
      for (int i = 0; i < 10; i++) begin
         exv = (i == 2) || (i == 5) || (i == 8);
         applyStimulus(0, 1, 16'h0026 + 16'(i * 2), exv, 16'h0000, 6'd5, 0, exv);
         checkOutput("en0_pred", {15'd0, pred_taken}, 16'd0);
      end
      applyStimulus(1, 1, 16'h0026, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("en0_ghr",  {10'd0, pred_ghr},   16'd22);
      checkOutput("en0_cnt",  mispred_cnt,         16'd4);
      checkOutput("en0_tbl",  {15'd0, pred_taken}, 16'd1);

      // Reset in the middle of a disabled sequence.
      applyStimulus(0, 1, 16'h0010, 1, 16'h0000, 6'd5, 1, 1);
      applyStimulus(0, 1, 16'h0010, 1, 16'h0000, 6'd5, 1, 1);
      checkOutput("pre_rst_ghr", {10'd0, pred_ghr}, 16'd45);
      checkOutput("pre_rst_cnt", mispred_cnt,       16'd5);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_ghr", {10'd0, pred_ghr}, 16'd0);
      checkOutput("async_rst_cnt", mispred_cnt,       16'd0);
      @(posedge clk);
      @(negedge clk);
      setIdle();
      rst_n = 1'b1;

      // Table back to weak-NT: indices 8, 5 and 0 all predict not-taken.
      applyStimulus(1, 1, 16'h0010, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("post_rst_ghr",   {10'd0, pred_ghr},   16'd0);
      checkOutput("post_rst_cnt",   mispred_cnt,         16'd0);
      checkOutput("post_rst_idx8",  {15'd0, pred_taken}, 16'd0);
      applyStimulus(1, 1, 16'h000A, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("post_rst_idx5",  {15'd0, pred_taken}, 16'd0);
      applyStimulus(1, 1, 16'h0000, 0, 16'h0000, 6'd0, 0, 0);
      checkOutput("post_rst_idx0",  {15'd0, pred_taken}, 16'd0);

      applyStimulus(1, 0, 16'h0000, 0, 16'h0000, 6'd0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
